// File: rtl/video_pkg.sv
// Shared VGA 640x480@60 timing constants, framebuffer geometry and colour type
// for the sprite framebuffer slice.
package video_pkg;

  localparam logic [9:0] H_VISIBLE = 10'd640;
  localparam logic [9:0] H_FRONT   = 10'd16;
  localparam logic [9:0] H_SYNC    = 10'd96;
  localparam logic [9:0] H_BACK    = 10'd48;
  localparam logic [9:0] H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam logic [9:0] V_VISIBLE = 10'd480;
  localparam logic [9:0] V_FRONT   = 10'd10;
  localparam logic [9:0] V_SYNC    = 10'd2;
  localparam logic [9:0] V_BACK    = 10'd33;
  localparam logic [9:0] V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [7:0]  FB_WIDTH  = 8'd160;
  localparam logic [6:0]  FB_HEIGHT = 7'd120;
  localparam logic [14:0] FB_DEPTH  = 15'd19200;

  typedef logic [2:0] colour_t;
  localparam colour_t BG_DEFAULT = 3'b000;

  typedef enum logic {ST_CLEAR, ST_RUN} fb_state_t;

  // row*160 + col built from shifts so no multiplier is needed
  function automatic logic [14:0] fb_addr(input logic [7:0] col, input logic [6:0] row);
    return ({8'd0, row} << 7) + ({8'd0, row} << 5) + {7'd0, col};
  endfunction

endpackage

// File: rtl/fb_ram.sv
// 19200 x 3-bit simple dual-port framebuffer RAM: one write port, one registered
// read port; a same-address read during a write returns the old contents.
module fb_ram
  import video_pkg::*;
(
  input  logic        clk,
  input  logic        we,
  input  logic [14:0] waddr,
  input  colour_t     wdata,
  input  logic [14:0] raddr,
  output colour_t     rdata
);

  colour_t mem [0:FB_DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/pixel_framebuffer.sv
// Pixel-write sink with a 160x120x3 framebuffer, hardware clear and continuous
// 640x480@60 scan-out at 4x4 display pixels per stored pixel.
module pixel_framebuffer
  import video_pkg::*;
#(
  parameter logic [7:0] WIDTH      = FB_WIDTH,
  parameter logic [6:0] HEIGHT     = FB_HEIGHT,
  parameter int         SCALE_LOG2 = 2,
  parameter colour_t    BACKGROUND = BG_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       plot,
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic [2:0] colour,
  input  logic       clear_req,
  output logic       busy,
  output logic       frame_start,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       vga_r,
  output logic       vga_g,
  output logic       vga_b
);

  fb_state_t   state, state_next;
  logic [14:0] clr_addr, clr_addr_next;
  logic        we;
  logic [14:0] waddr;
  colour_t     wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_CLEAR;
      clr_addr <= 15'd0;
    end else begin
      state    <= state_next;
      clr_addr <= clr_addr_next;
    end
  end

  // plot is a fire-and-forget strobe with no back-pressure; busy is advisory only
  always_comb begin
    state_next    = state;
    clr_addr_next = clr_addr;
    we            = 1'b0;
    waddr         = clr_addr;
    wdata         = BACKGROUND;
    busy          = 1'b0;
    case (state)
      ST_CLEAR: begin
        busy          = 1'b1;
        we            = !reset;
        clr_addr_next = clr_addr + 15'd1;
        if (clr_addr == FB_DEPTH - 15'd1) begin
          state_next    = ST_RUN;
          clr_addr_next = clr_addr;
        end
      end
      ST_RUN: begin
        if (clear_req) begin
          state_next    = ST_CLEAR;
          clr_addr_next = 15'd0;
        end else if (plot && (x < WIDTH) && (y < HEIGHT)) begin
          we    = 1'b1;
          waddr = fb_addr(x, y);
          wdata = colour;
        end
      end
      default: state_next = ST_CLEAR;
    endcase
  end

  logic [9:0] h_cnt, v_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt       <= 10'd0;
      v_cnt       <= 10'd0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= (h_cnt == H_TOTAL - 10'd1) && (v_cnt == V_TOTAL - 10'd1);
      if (h_cnt == H_TOTAL - 10'd1) begin
        h_cnt <= 10'd0;
        v_cnt <= (v_cnt == V_TOTAL - 10'd1) ? 10'd0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  logic        visible, hs_raw, vs_raw;
  logic [14:0] raddr;
  colour_t     rdata;

  always_comb begin
    visible = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE);
    hs_raw  = !((h_cnt >= H_VISIBLE + H_FRONT) && (h_cnt < H_VISIBLE + H_FRONT + H_SYNC));
    vs_raw  = !((v_cnt >= V_VISIBLE + V_FRONT) && (v_cnt < V_VISIBLE + V_FRONT + V_SYNC));
    raddr   = visible ? fb_addr(8'(h_cnt >> SCALE_LOG2), 7'(v_cnt >> SCALE_LOG2)) : 15'd0;
  end

  fb_ram u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rdata)
  );

  // Syncs and the visible flag ride alongside the RAM read so all outputs align
  logic vis_d1, hs_d1, vs_d1;

  always_ff @(posedge clk) begin
    if (reset) begin
      vis_d1      <= 1'b0;
      hs_d1       <= 1'b1;
      vs_d1       <= 1'b1;
      vga_blank_n <= 1'b0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      {vga_r, vga_g, vga_b} <= 3'b000;
    end else begin
      vis_d1      <= visible;
      hs_d1       <= hs_raw;
      vs_d1       <= vs_raw;
      vga_blank_n <= vis_d1;
      vga_hs      <= hs_d1;
      vga_vs      <= vs_d1;
      {vga_r, vga_g, vga_b} <= vis_d1 ? rdata : 3'b000;
    end
  end

endmodule

// File: tb/tb_pixel_framebuffer.sv
// Bench for pixel_framebuffer: table of plots with pinned display samples, hand-written
// clear/reset sequences, and a per-cycle reference model of the scanned picture.
module tb_pixel_framebuffer;

  localparam int DEPTH  = 19200;
  localparam int LINE   = 800;
  localparam int FRAME  = 420000;
  localparam int CLR_N  = 19200;
  localparam int NV     = 17;
  localparam int T_END  = 67200;

  logic       clk = 1'b0;
  logic       reset, plot, clear_req;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       busy, frame_start, vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b;

  always #20 clk = ~clk;

  pixel_framebuffer dut (
    .clk         (clk),
    .reset       (reset),
    .plot        (plot),
    .x           (x),
    .y           (y),
    .colour      (colour),
    .clear_req   (clear_req),
    .busy        (busy),
    .frame_start (frame_start),
    .vga_hs      (vga_hs),
    .vga_vs      (vga_vs),
    .vga_blank_n (vga_blank_n),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b)
  );

  // edges since the last reset edge
  int t = 0;
  always @(posedge clk) begin
    if (reset) t = 0;
    else t = t + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0d)", name, act, req, t);
    end
  endtask

  typedef struct { bit is_clear; int e; int a; logic [2:0] c; } ev_t;
  ev_t ev_q[$];

  logic [2:0] fb_cur [DEPTH];
  logic [2:0] fb_old [DEPTH];
  bit         old_known [DEPTH];
  int         fb_cs;
  int         fb_idx;
  bit         tracking = 1'b0;

  function automatic bit model_busy(input int tt);
    int cs = 0;
    foreach (ev_q[i]) if (ev_q[i].is_clear && ev_q[i].e <= tt) cs = ev_q[i].e;
    return tt < cs + CLR_N;
  endfunction

  task automatic apply_event(input ev_t ev);
    if (!ev.is_clear) begin
      fb_cur[ev.a] = ev.c;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        fb_old[i]    = fb_cur[i];
        old_known[i] = 1'b1;
        fb_cur[i]    = 3'b000;
      end
      fb_cs = ev.e;
    end
  endtask

  typedef struct {
    bit p; logic [7:0] x; logic [6:0] y; logic [2:0] c;
    bit chk; int ch; int cv; logic [2:0] req;
  } vec_t;
  vec_t       vt [NV];
  logic [2:0] cap_val [NV];
  bit         cap_done [NV];
  bit         cap_arm = 1'b0;

  string sig_name [6] = '{"busy", "frame_start", "vga_hs", "vga_vs", "vga_blank_n", "rgb"};
  int mm [6];
  int first_act [6];
  int first_req [6];
  int blank_cnt = 0;
  int hs_low_cnt = 0;

  task automatic flush_line(input int ln);
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (mm[k] != 0) begin
        errors++;
        $display("FAIL line %0d %s: %0d bad cycles, first got %0d expected %0d",
                 ln, sig_name[k], mm[k], first_act[k], first_req[k]);
      end
      mm[k] = 0;
    end
    check($sformatf("line %0d blank_n high count", ln), blank_cnt, (ln < 480) ? 640 : 0);
    check($sformatf("line %0d hs low count", ln), hs_low_cnt, 96);
    blank_cnt  = 0;
    hs_low_cnt = 0;
  endtask

  always @(negedge clk) begin
    if (tracking) begin
      int ts, h, v, a;
      int act [6];
      int ex [6];
      bit vis, rgb_known;
      while (fb_idx < ev_q.size() && ev_q[fb_idx].e <= t - 2) begin
        apply_event(ev_q[fb_idx]);
        fb_idx++;
      end
      ex[0] = int'(model_busy(t));
      ex[1] = (t > 0 && t % FRAME == 0) ? 1 : 0;
      rgb_known = 1'b1;
      h = -1;
      v = -1;
      if (t < 2) begin
        ex[2] = 1; ex[3] = 1; ex[4] = 0; ex[5] = 0;
      end else begin
        ts  = t - 2;
        h   = ts % LINE;
        v   = (ts / LINE) % 525;
        vis = (h < 640) && (v < 480);
        ex[2] = (h >= 656 && h < 752) ? 0 : 1;
        ex[3] = (v == 490 || v == 491) ? 0 : 1;
        ex[4] = int'(vis);
        ex[5] = 0;
        if (vis) begin
          a = (v / 4) * 160 + h / 4;
          if (ts < fb_cs + 1 + a) begin
            rgb_known = old_known[a];
            ex[5] = int'(fb_old[a]);
          end else begin
            ex[5] = int'(fb_cur[a]);
          end
        end
      end
      act[0] = int'(busy);
      act[1] = int'(frame_start);
      act[2] = int'(vga_hs);
      act[3] = int'(vga_vs);
      act[4] = int'(vga_blank_n);
      act[5] = int'({vga_r, vga_g, vga_b});
      for (int k = 0; k < 6; k++) begin
        if ((k != 5 || rgb_known) && act[k] != ex[k]) begin
          if (mm[k] == 0) begin
            first_act[k] = act[k];
            first_req[k] = ex[k];
          end
          mm[k]++;
        end
      end
      blank_cnt  += int'(vga_blank_n);
      hs_low_cnt += int'(!vga_hs);
      if (cap_arm && h >= 0) begin
        for (int i = 0; i < NV; i++) begin
          if (vt[i].chk && !cap_done[i] && vt[i].ch == h && vt[i].cv == v) begin
            cap_val[i]  = {vga_r, vga_g, vga_b};
            cap_done[i] = 1'b1;
          end
        end
      end
      if (t % LINE == LINE - 1) flush_line(t / LINE);
    end
  end

  task automatic drive(input bit p, input logic [7:0] xx, input logic [6:0] yy,
                       input logic [2:0] cc, input bit cr);
    int e;
    ev_t ev;
    plot = p; x = xx; y = yy; colour = cc; clear_req = cr;
    e = t + 1;
    if (!model_busy(t)) begin
      if (cr) begin
        ev = '{1'b1, e, 0, 3'b000};
        ev_q.push_back(ev);
      end else if (p && xx < 8'd160 && yy < 7'd120) begin
        ev = '{1'b0, e, int'(yy) * 160 + int'(xx), cc};
        ev_q.push_back(ev);
      end
    end
    @(negedge clk);
    plot = 1'b0;
    clear_req = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 25000) begin
      @(negedge clk);
      n++;
    end
    if (busy) check({name, " busy timeout"}, int'(busy), 0);
  endtask

  initial begin
    #(40 * 90000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n0, ce;
    logic [7:0] xx;
    logic [6:0] yy;
    logic [2:0] cc;

    vt[0]  = '{1'b1, 8'd80,  7'd13, 3'd7, 1'b1, 320, 52, 3'd7};
    vt[1]  = '{1'b0, 8'd0,   7'd0,  3'd0, 1'b1, 323, 55, 3'd7};
    vt[2]  = '{1'b0, 8'd0,   7'd0,  3'd0, 1'b1, 319, 52, 3'd0};
    vt[3]  = '{1'b0, 8'd0,   7'd0,  3'd0, 1'b1, 324, 52, 3'd0};
    vt[4]  = '{1'b0, 8'd0,   7'd0,  3'd0, 1'b1, 320, 51, 3'd0};
    vt[5]  = '{1'b0, 8'd0,   7'd0,  3'd0, 1'b1, 320, 56, 3'd0};
    vt[6]  = '{1'b1, 8'd160, 7'd14, 3'd7, 1'b1, 0,   60, 3'd0};
    vt[7]  = '{1'b1, 8'd200, 7'd15, 3'd7, 1'b1, 160, 64, 3'd0};
    vt[8]  = '{1'b1, 8'd159, 7'd16, 3'd2, 1'b1, 636, 64, 3'd2};
    vt[9]  = '{1'b1, 8'd0,   7'd16, 3'd4, 1'b1, 3,   67, 3'd4};
    vt[10] = '{1'b1, 8'd10,  7'd16, 3'd3, 1'b0, 0,   0,  3'd0};
    vt[11] = '{1'b1, 8'd10,  7'd16, 3'd6, 1'b1, 40,  64, 3'd6};
    vt[12] = '{1'b1, 8'd0,   7'd120, 3'd7, 1'b0, 0,  0,  3'd0};
    vt[13] = '{1'b0, 8'd0,   7'd0,  3'd0, 1'b1, 20,  68, 3'd0};
    vt[14] = '{1'b0, 8'd0,   7'd0,  3'd0, 1'b1, 24,  68, 3'd0};
    vt[15] = '{1'b0, 8'd0,   7'd0,  3'd0, 1'b1, 28,  72, 3'd0};
    vt[16] = '{1'b1, 8'd100, 7'd16, 3'd5, 1'b1, 403, 65, 3'd5};
    for (int i = 0; i < NV; i++) begin
      cap_done[i] = 1'b0;
      cap_val[i]  = 3'b000;
    end
    for (int k = 0; k < 6; k++) begin
      mm[k] = 0; first_act[k] = 0; first_req[k] = 0;
    end

    reset = 1'b1; plot = 1'b0; clear_req = 1'b0; x = 8'd0; y = 7'd0; colour = 3'd0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // First clear is interrupted by a reset about 5000 addresses in
    n0 = 0;
    repeat (5000) begin
      @(negedge clk);
      if (!busy) n0++;
    end
    check("busy low during first clear", n0, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ev_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      fb_cur[i] = 3'b000; fb_old[i] = 3'b000; old_known[i] = 1'b0;
    end
    fb_cs = 0;
    fb_idx = 0;
    tracking = 1'b1;
    check("reset state {busy,fs,hs,vs,blank,rgb}",
          int'({busy, frame_start, vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b}), 8'hB0);

    wait_idle("restarted clear");
    check("restarted clear length", t, CLR_N);

    drive(1'b1, 8'd5, 7'd17, 3'd5, 1'b0);
    drive(1'b1, 8'd6, 7'd17, 3'd3, 1'b1);
    ce = t;
    repeat (100) @(negedge clk);
    check("busy during requested clear", int'(busy), 1);
    drive(1'b1, 8'd7, 7'd18, 3'd7, 1'b0);
    wait_idle("requested clear");
    check("requested clear length", t - ce, CLR_N);

    for (int i = 0; i < NV; i++) drive(vt[i].p, vt[i].x, vt[i].y, vt[i].c, 1'b0);
    cap_arm = 1'b1;

    repeat (40) begin
      xx = 8'($urandom_range(0, 159));
      if ($urandom_range(0, 7) == 0) xx = 8'($urandom_range(160, 255));
      yy = 7'($urandom_range(19, 20));
      cc = 3'($urandom_range(0, 7));
      drive(1'b1, xx, yy, cc, 1'b0);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    while (t < T_END) @(negedge clk);
    tracking = 1'b0;

    for (int i = 0; i < NV; i++) begin
      if (vt[i].chk) begin
        if (!cap_done[i]) check($sformatf("vec %0d sample taken", i), 0, 1);
        else check($sformatf("vec %0d rgb at (%0d,%0d)", i, vt[i].ch, vt[i].cv),
                   int'(cap_val[i]), int'(vt[i].req));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_framebuffer.md
Name: pixel_framebuffer

Overview:
- Consumer end of the sprite pixel-write stream (plot, x, y, colour) that the bird, crosshair and background datapaths produce.
- Stores writes in a 160x120x3-bit on-chip framebuffer.
- Scans the framebuffer out continuously as 640x480@60 VGA, with each stored pixel shown as a 4x4 block.
- Provides a hardware screen clear and a per-frame tick for the game FSMs.

Parameters:
- WIDTH, 160, framebuffer columns
- HEIGHT, 120, framebuffer rows
- SCALE_LOG2, 2, log2 of the display pixels per framebuffer pixel in each axis
- BACKGROUND, 3'b000, colour written by a clear

Ports:
- clk  in  1  25 MHz pixel clock; the only clock
- reset  in  1  synchronous, active-high reset
- plot  in  1  write strobe for a single pixel
- x  in  8  write column
- y  in  7  write row
- colour  in  3  write colour {r,g,b}
- clear_req  in  1  one-cycle request to fill the framebuffer with BACKGROUND
- busy  out  1  high while a clear is in progress
- frame_start  out  1  one-cycle pulse at the start of each frame
- vga_hs  out  1  horizontal sync, active-low
- vga_vs  out  1  vertical sync, active-low
- vga_blank_n  out  1  high inside the visible area
- vga_r  out  1  red
- vga_g  out  1  green
- vga_b  out  1  blue

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (reset). All state changes occur on the rising edge of clk.
- Reset values: vga_hs=1, vga_vs=1, vga_blank_n=0, rgb=000, frame_start=0, busy=1, h_cnt=0, v_cnt=0, clear address=0, FSM=CLEAR. The framebuffer is not reset directly; the CLEAR state wipes it.
- FSM CLEAR:
  - Writes BACKGROUND to address clr_addr each cycle, then increments clr_addr.
  - After writing address 19199, moves to RUN and busy goes to 0. A full clear is exactly 19200 cycles with busy=1.
- FSM RUN:
  - busy=0.
  - plot=1 with x<WIDTH and y<HEIGHT writes colour to address y*160+x (15-bit; compute as (y<<7)+(y<<5)+x). The write is visible to scan-out from the next cycle.
  - plot with x>=160 or y>=120 is dropped. It must not alias: x=160,y=0 must not hit (0,1).
  - clear_req=1 sets clr_addr=0, moves to CLEAR and drops any simultaneous plot.
- In CLEAR, plot and clear_req are ignored.
- Reset during CLEAR restarts the clear at address 0.
- Scan-out counters run in every FSM state and are independent of writes:
  - h_cnt 0..799, wraps to 0.
  - v_cnt 0..524, increments when h_cnt wraps, then wraps to 0.
- Timing at counter stage:
  - visible = h<640 && v<480
  - hs_raw low for h in 656..751
  - vs_raw low for v in 490..491
- Read address: (v>>SCALE_LOG2)*160 + (h>>SCALE_LOG2) when visible, else don't-care.
- Read pipeline latency is 2 cycles for colour and syncs alike:
  - stage 1: registered RAM read (dual-port RAM, read-during-write to the same address returns old data)
  - stage 2: output registers
- hs_raw, vs_raw and visible are delayed by the same 2 stages. rgb is forced to 000 when the delayed visible flag is 0.
- frame_start: 1 for one cycle when the counters wrap to (h=0,v=0), undelayed. Period is 420000 cycles. It is suppressed during reset.
- The display continues during CLEAR and shows partially cleared contents.

Decomposition:
- Shared package (video_pkg) holds:
  - H_VISIBLE=640, H_FRONT=16, H_SYNC=96, H_BACK=48, H_TOTAL=800
  - V_VISIBLE=480, V_FRONT=10, V_SYNC=2, V_BACK=33, V_TOTAL=525
  - FB_WIDTH=160, FB_HEIGHT=120, FB_DEPTH=19200
  - colour_t (3-bit) and the BACKGROUND default
- Single sub-module fb_ram: 19200x3 simple dual-port RAM with one write port and one registered read port. It is inferable as block RAM and does not need a reset.

Test Plan:
- Assert reset 1 cycle, then release -> busy=1 for exactly 19200 cycles, then 0. Next, the first frame_start occurs when the counters reach (0,0). All visible rgb=000.
- After busy=0, plot x=80 y=90 colour=111 -> rgb=111 two cycles after the counters hit h=320..323, v=360..363. The pixel at h=319/324 and v=359/364 stays 000.
- plot x=160 y=0 colour=111, and plot x=0 y=120 -> no framebuffer change. The block at h=0..3, v=4..7 (fb (0,1)) stays 000.
- Free-run 2 frames -> vga_hs low 96 cycles per line starting 2 cycles after h=656. vga_vs low for lines 490-491 (delayed 2 cycles). frame_start period is 420000. vga_blank_n is high exactly 640 cycles per visible line.
- Fill fb (5,5) with 101, then clear_req with a simultaneous plot (6,6) -> busy for 19200 cycles. Both (5,5) and (6,6) read 000. A plot during busy is dropped.
- Reset asserted when clr_addr is about 5000 -> busy stays 1 and the clear restarts: busy falls exactly 19200 cycles after reset release.
